// File: rtl/pedal_pkg.sv
// Shared types and width constants for the pedal SRAM scheduler.
package pedal_pkg;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_GAIN_W   = 8;
  localparam int unsigned DEF_NUM_TAPS = 4;

  // Headroom for NUM_TAPS full-scale products at unity-ish gain.
  function automatic int unsigned acc_width(int unsigned data_w, int unsigned gain_w);
    return data_w + gain_w + 2;
  endfunction

  localparam int unsigned ACC_W = acc_width(DEF_DATA_W, DEF_GAIN_W);

  localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWrite,
    StDone,
    StHIssue,
    StHWait
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Signed add followed by arithmetic right shift, saturated to OUT_W bits.
module sat_add #(
  parameter int unsigned IN_W  = 17,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [OUT_W-1:0] y
);

  localparam int unsigned SumW = IN_W + 1;

  logic signed [SumW-1:0] sum, shr, max_v, min_v;

  assign sum   = SumW'(a) + SumW'(b);
  assign shr   = sum >>> SHIFT;
  assign max_v = SumW'($signed({1'b0, {(OUT_W-1){1'b1}}}));
  assign min_v = SumW'($signed({1'b1, {(OUT_W-1){1'b0}}}));

  always_comb begin
    if (shr > max_v) begin
      y = max_v[OUT_W-1:0];
    end else if (shr < min_v) begin
      y = min_v[OUT_W-1:0];
    end else begin
      y = shr[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/sram_sched.sv
// Per-sample tap/record scheduler and host arbiter for the shared delay SRAM.
// Define SRAM_SCHED_OVR_CNT_EN to add the ovr_count/ovr_clr dropped-strobe counter.
module sram_sched
  import pedal_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter int unsigned GAIN_W   = DEF_GAIN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_stb,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic                     record,
  input  logic                     loop,
  input  logic                     delay_reverb,
  input  logic [GAIN_W-1:0]        gain,
  input  logic [2:0]               num_taps,
  input  logic [ADDR_W-1:0]        delay_len,
  output logic signed [DATA_W-1:0] out_sample,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun,
`ifdef SRAM_SCHED_OVR_CNT_EN
  output logic [7:0]               ovr_count,
  input  logic                     ovr_clr,
`endif
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic [DATA_W-1:0]        host_wdata,
  output logic [DATA_W-1:0]        host_rdata,
  output logic                     host_ack,
  output logic                     mem_csb,
  output logic                     mem_web,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout
);

  localparam int unsigned AccW    = acc_width(DATA_W, GAIN_W);
  localparam int unsigned ProdW   = DATA_W + GAIN_W + 1;
  localparam logic [2:0]  MaxTaps = 3'(NUM_TAPS);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]        wr_ptr_q, rd_addr_q, dlen_q;
  logic [2:0]               taps_q, tap_q, taps_in;
  logic [GAIN_W-1:0]        gain_q, coef_q;
  logic signed [DATA_W-1:0] in_q, wet, rev_din;
  logic                     rec_q, loop_q, rev_q, pending_q, start, drop;
  logic signed [AccW-1:0]   acc_q;
  logic signed [ProdW-1:0]  prod;
  logic [DATA_W-1:0]        host_rdata_q;

  assign taps_in = (num_taps > MaxTaps) ? MaxTaps : num_taps;
  assign start   = (state_q == StIdle) && (sample_stb || pending_q);
  assign drop    = (state_q != StIdle) && sample_stb && pending_q;
  assign prod    = $signed(mem_dout) * $signed({1'b0, coef_q});

  sat_add #(.IN_W(AccW), .SHIFT(GAIN_W), .OUT_W(DATA_W)) u_wet (
    .a(acc_q),
    .b('0),
    .y(wet)
  );

  sat_add #(.IN_W(DATA_W), .SHIFT(0), .OUT_W(DATA_W)) u_rev (
    .a(in_q),
    .b(wet),
    .y(rev_din)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start)         state_d = (taps_in == 3'd0) ? StWrite : StRdIssue;
        else if (host_req) state_d = StHIssue;
      end
      StRdIssue: state_d = StRdWait;
      StRdWait:  state_d = (tap_q == taps_q - 3'd1) ? StWrite : StRdIssue;
      StWrite:   state_d = StDone;
      StDone:    state_d = StIdle;
      StHIssue:  state_d = StHWait;
      StHWait:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    host_ack   = (state_q == StHWait);
    host_rdata = host_rdata_q;
    mem_csb    = 1'b1;
    mem_web    = 1'b1;
    mem_addr   = '0;
    mem_din    = '0;
    case (state_q)
      StRdIssue: begin
        mem_csb  = 1'b0;
        mem_addr = rd_addr_q;
      end
      StWrite: begin
        // A frozen loop skips the write unless recording overdubs it.
        if (rec_q || !loop_q) begin
          mem_csb  = 1'b0;
          mem_web  = 1'b0;
          mem_addr = wr_ptr_q;
          mem_din  = (rec_q && rev_q) ? rev_din : in_q;
        end
      end
      StHIssue: begin
        mem_csb  = 1'b0;
        mem_web  = ~host_we;
        mem_addr = host_addr;
        mem_din  = host_wdata;
      end
      StHWait: begin
        if (!host_we) host_rdata = mem_dout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_addr_q    <= '0;
      dlen_q       <= '0;
      taps_q       <= '0;
      tap_q        <= '0;
      gain_q       <= '0;
      coef_q       <= '0;
      in_q         <= '0;
      rec_q        <= 1'b0;
      loop_q       <= 1'b0;
      rev_q        <= 1'b0;
      acc_q        <= '0;
      pending_q    <= 1'b0;
      overrun      <= 1'b0;
      out_sample   <= '0;
      out_valid    <= 1'b0;
      host_rdata_q <= '0;
`ifdef SRAM_SCHED_OVR_CNT_EN
      ovr_count    <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            in_q      <= in_sample;
            rec_q     <= record;
            loop_q    <= loop;
            rev_q     <= delay_reverb;
            gain_q    <= gain;
            coef_q    <= gain;
            dlen_q    <= delay_len;
            taps_q    <= taps_in;
            tap_q     <= '0;
            acc_q     <= '0;
            rd_addr_q <= wr_ptr_q - delay_len;
          end
        end
        StRdWait: begin
          acc_q     <= acc_q + AccW'(prod);
          coef_q    <= GAIN_W'(((2*GAIN_W)'(coef_q) * (2*GAIN_W)'(gain_q)) >> GAIN_W);
          tap_q     <= tap_q + 3'd1;
          rd_addr_q <= rd_addr_q - dlen_q;
        end
        StWrite: wr_ptr_q <= wr_ptr_q + 1'b1;
        StDone: begin
          out_sample <= wet;
          out_valid  <= 1'b1;
        end
        StHWait: begin
          if (!host_we) host_rdata_q <= mem_dout;
        end
        default: ;
      endcase

      // A strobe landing in the same IDLE cycle that consumes pending re-arms it.
      if (state_q == StIdle)  pending_q <= pending_q && sample_stb;
      else if (sample_stb)    pending_q <= 1'b1;

`ifdef SRAM_SCHED_OVR_CNT_EN
      if (ovr_clr) begin
        overrun   <= 1'b0;
        ovr_count <= '0;
      end else if (drop) begin
        overrun <= 1'b1;
        if (ovr_count != 8'hFF) ovr_count <= ovr_count + 8'd1;
      end
`else
      if (drop) overrun <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_sram_sched.sv
// Randomized bench for sram_sched against a frame-level reference model.
module tb_sram_sched;

  logic        clk, rst, sample_stb, record, loop, delay_reverb;
  logic [15:0] in_sample;
  logic [7:0]  gain, delay_len, host_addr;
  logic [2:0]  num_taps;
  logic [15:0] out_sample, host_wdata, host_rdata, mem_din, mem_dout;
  logic        out_valid, busy, overrun, host_req, host_we, host_ack;
  logic        mem_csb, mem_web, mem_init;
  logic [7:0]  mem_addr;

  int nvec = 0;
  int nerr = 0;

  sram_sched dut (
    .clk(clk), .rst(rst), .sample_stb(sample_stb), .in_sample(in_sample),
    .record(record), .loop(loop), .delay_reverb(delay_reverb), .gain(gain),
    .num_taps(num_taps), .delay_len(delay_len), .out_sample(out_sample),
    .out_valid(out_valid), .busy(busy), .overrun(overrun), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .mem_csb(mem_csb), .mem_web(mem_web),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: one-cycle read latency.
  logic [15:0] sram [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= '0;
    end else if (!mem_csb) begin
      if (!mem_web) sram[mem_addr] <= mem_din;
      else          mem_dout <= sram[mem_addr];
    end
  end

  int wq_addr[$];
  int wq_data[$];
  int rq_addr[$];
  always @(negedge clk) begin
    if (!rst && !mem_csb) begin
      if (!mem_web) begin
        wq_addr.push_back(int'(mem_addr));
        wq_data.push_back(int'($signed(mem_din)));
      end else begin
        rq_addr.push_back(int'(mem_addr));
      end
    end
  end

  // Reference model state: buffer contents and write pointer.
  int ref_mem[256];
  int ref_wp;

  function automatic int sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_frame(output bit exp_wr, output int exp_addr, output int exp_din,
                             output int exp_out, output int exp_lat);
    int t, c, wet, din;
    longint acc;
    t   = (num_taps > 3'd4) ? 4 : int'(num_taps);
    acc = 0;
    c   = int'(gain);
    for (int k = 0; k < t; k++) begin
      acc += longint'(ref_mem[(ref_wp - (k + 1) * int'(delay_len)) & 255]) * c;
      c = (c * int'(gain)) >> 8;
    end
    wet      = sat16(acc >>> 8);
    din      = int'($signed(in_sample));
    exp_out  = wet;
    exp_addr = ref_wp;
    exp_wr   = record || !loop;
    exp_din  = (record && delay_reverb) ? sat16(longint'(din) + wet) : din;
    exp_lat  = 3 + 2 * t;
    if (exp_wr) ref_mem[ref_wp] = exp_din;
    ref_wp = (ref_wp + 1) & 255;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ref_wp = 0;
    wq_addr.delete(); wq_data.delete(); rq_addr.delete();
  endtask

  // Pulse one strobe and wait (bounded) for out_valid; lat = -1 on timeout.
  task automatic do_frame(output int o, output int lat);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    o = int'($signed(out_sample));
    if (!out_valid) lat = -1;
  endtask

  task automatic host_op(input bit we, input int addr, input int data,
                         output int rd, output int cyc);
    host_we    = we;
    host_addr  = addr[7:0];
    host_wdata = data[15:0];
    host_req   = 1'b1;
    cyc = 0;
    while (!host_ack && cyc < 20) begin
      tick();
      cyc++;
    end
    rd = int'($signed(host_rdata));
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    nvec++;
    if ({out_sample, out_valid, busy, overrun, host_ack} !== 20'h0) begin
      $display("FAIL reset_outputs: got %h, expected 0",
               {out_sample, out_valid, busy, overrun, host_ack});
      nerr++;
    end
    nvec++;
    if (host_rdata !== 16'h0) begin
      $display("FAIL reset_host_rdata: got %h, expected 0", host_rdata);
      nerr++;
    end
    nvec++;
    if ({mem_csb, mem_web} !== 2'b11) begin
      $display("FAIL reset_mem_ctl: got %b, expected 11", {mem_csb, mem_web});
      nerr++;
    end
    nvec++;
    if ({mem_addr, mem_din} !== 24'h0) begin
      $display("FAIL reset_mem_bus: got %h, expected 0", {mem_addr, mem_din});
      nerr++;
    end
    rst = 1'b0;
    ref_wp = 0;
  endtask

  task automatic test_delay;
    int o, lat, ea, ed, eo, el;
    bit ew;
    apply_reset();
    num_taps = 3'd1; delay_len = 8'd4; gain = 8'hFF;
    record = 1'b1; loop = 1'b0; delay_reverb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_sample = (i == 0) ? 16'd1000 : 16'd0;
      model_frame(ew, ea, ed, eo, el);
      do_frame(o, lat);
      nvec++;
      if (lat !== 5) begin
        $display("FAIL delay_latency[%0d]: got %0d, expected 5", i, lat);
        nerr++;
      end
      nvec++;
      if (o !== eo) begin
        $display("FAIL delay_out[%0d]: got %0d, expected %0d", i, o, eo);
        nerr++;
      end
    end
    nvec++;
    if (o !== 996) begin
      $display("FAIL delay_impulse: got %0d, expected 996", o);
      nerr++;
    end
  endtask

  task automatic test_wrap;
    int o, lat, ea, ed, eo, el, bad;
    bit ew;
    apply_reset();
    record = 1'b1; loop = 1'b0; delay_reverb = 1'b0; num_taps = 3'd0;
    bad = 0;
    for (int i = 0; i < 258; i++) begin
      in_sample = 16'($urandom);
      model_frame(ew, ea, ed, eo, el);
      do_frame(o, lat);
      if (lat != 3 || o != 0) bad++;
    end
    nvec++;
    if (bad !== 0) begin
      $display("FAIL wrap_fill: got %0d bad frames, expected 0", bad);
      nerr++;
    end
    num_taps = 3'd1; delay_len = 8'd3; gain = 8'h80;
    rq_addr.delete(); wq_addr.delete(); wq_data.delete();
    model_frame(ew, ea, ed, eo, el);
    do_frame(o, lat);
    nvec++;
    if (rq_addr.size() !== 1 || rq_addr[0] !== 255) begin
      $display("FAIL wrap_tap_addr: got %0d, expected 255",
               (rq_addr.size() > 0) ? rq_addr[0] : -1);
      nerr++;
    end
    nvec++;
    if (wq_addr.size() !== 1 || wq_addr[0] !== 2) begin
      $display("FAIL wrap_wr_ptr: got %0d, expected 2",
               (wq_addr.size() > 0) ? wq_addr[0] : -1);
      nerr++;
    end
    nvec++;
    if (o !== eo) begin
      $display("FAIL wrap_out: got %0d, expected %0d", o, eo);
      nerr++;
    end
  endtask

  task automatic test_loop;
    int o, lat, ea, ed, eo, el, bad;
    int outs[300];
    bit ew;
    record = 1'b0; loop = 1'b1; delay_reverb = 1'b0;
    num_taps = 3'd2; gain = 8'hC0; delay_len = 8'($urandom_range(1, 255));
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 300; i++) begin
      in_sample = 16'($urandom);
      model_frame(ew, ea, ed, eo, el);
      do_frame(o, lat);
      outs[i] = o;
      nvec++;
      if (o !== eo || lat !== el) begin
        $display("FAIL loop_out[%0d]: got %0d/%0d clks, expected %0d/%0d", i, o, lat, eo, el);
        nerr++;
      end
    end
    nvec++;
    if (wq_addr.size() !== 0) begin
      $display("FAIL loop_no_write: got %0d writes, expected 0", wq_addr.size());
      nerr++;
    end
    bad = 0;
    for (int i = 256; i < 300; i++) if (outs[i] != outs[i-256]) bad++;
    nvec++;
    if (bad !== 0) begin
      $display("FAIL loop_period: got %0d differing samples, expected 0", bad);
      nerr++;
    end
  endtask

  task automatic test_random;
    int o, lat, ea, ed, eo, el;
    bit ew;
    for (int i = 0; i < 60; i++) begin
      in_sample = 16'($urandom); gain = 8'($urandom); num_taps = 3'($urandom);
      delay_len = 8'($urandom); record = 1'($urandom); loop = 1'($urandom);
      delay_reverb = 1'($urandom);
      wq_addr.delete(); wq_data.delete();
      model_frame(ew, ea, ed, eo, el);
      do_frame(o, lat);
      nvec++;
      if (o !== eo || lat !== el) begin
        $display("FAIL rand_out[%0d]: got %0d/%0d clks, expected %0d/%0d", i, o, lat, eo, el);
        nerr++;
      end
      nvec++;
      if (wq_addr.size() !== int'(ew) ||
          (ew && (wq_addr[0] !== ea || wq_data[0] !== ed))) begin
        $display("FAIL rand_write[%0d]: got %0d writes, expected %0d at %0d data %0d",
                 i, wq_addr.size(), ew, ea, ed);
        nerr++;
      end
    end
  endtask

  task automatic test_reverb_sat;
    int o, lat, ea, ed, eo, el;
    bit ew;
    delay_reverb = 1'b1; record = 1'b1; loop = 1'b0; gain = 8'hFF;
    num_taps = 3'd1; delay_len = 8'd1; in_sample = 16'd32000;
    for (int i = 0; i < 8; i++) begin
      wq_addr.delete(); wq_data.delete();
      model_frame(ew, ea, ed, eo, el);
      do_frame(o, lat);
      nvec++;
      if (wq_data.size() !== 1 || wq_data[0] !== ed || wq_data[0] < 0) begin
        $display("FAIL reverb_din[%0d]: got %0d, expected %0d",
                 i, (wq_data.size() > 0) ? wq_data[0] : -99999, ed);
        nerr++;
      end
    end
    nvec++;
    if (wq_data.size() !== 1 || wq_data[0] !== 32767) begin
      $display("FAIL reverb_clip: got %0d, expected 32767",
               (wq_data.size() > 0) ? wq_data[0] : -99999);
      nerr++;
    end
  endtask

  task automatic test_arbitration;
    int n, m, rd, cyc, haddr, hdata, o1, o2, ea, ed, eo, el, ed2, eo2;
    bit ew, early;
    record = 1'b1; loop = 1'b0; delay_reverb = 1'b0; num_taps = 3'd1;
    delay_len = 8'd5; gain = 8'h90; in_sample = 16'($urandom);
    haddr = ref_wp;
    model_frame(ew, ea, ed, eo, el);
    host_we = 1'b0; host_addr = 8'(haddr); host_req = 1'b1; sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    n = 1; early = 1'b0;
    while (!out_valid && n < 40) begin
      if (host_ack) early = 1'b1;
      tick();
      n++;
    end
    nvec++;
    if (n !== 5 || early !== 1'b0 || int'($signed(out_sample)) !== eo) begin
      $display("FAIL arb_frame_first: got %0d clks early=%0d out %0d, expected 5/0/%0d",
               n, early, int'($signed(out_sample)), eo);
      nerr++;
    end
    m = 0;
    while (!host_ack && m < 10) begin
      tick();
      m++;
    end
    nvec++;
    if (m !== 2) begin
      $display("FAIL arb_ack_delay: got %0d, expected 2", m);
      nerr++;
    end
    nvec++;
    if (int'($signed(host_rdata)) !== ed) begin
      $display("FAIL arb_rdata: got %0d, expected %0d", int'($signed(host_rdata)), ed);
      nerr++;
    end
    host_req = 1'b0;
    tick();

    haddr = int'($urandom_range(0, 255));
    hdata = int'($signed(16'($urandom)));
    host_op(1'b1, haddr, hdata, rd, cyc);
    ref_mem[haddr] = hdata;
    host_op(1'b0, haddr, 0, rd, cyc);
    nvec++;
    if (cyc !== 2 || rd !== hdata) begin
      $display("FAIL host_rw: got %0d after %0d clks, expected %0d after 2", rd, cyc, hdata);
      nerr++;
    end

    // Three strobes inside one frame: second pends, third is dropped.
    num_taps = 3'd2;
    model_frame(ew, ea, ed, eo, el);
    model_frame(ew, ea, ed2, eo2, el);
    sample_stb = 1'b1; tick(); sample_stb = 1'b0; tick();
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    nvec++;
    if (overrun !== 1'b0) begin
      $display("FAIL arb_pending_no_ovr: got %b, expected 0", overrun);
      nerr++;
    end
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    nvec++;
    if (overrun !== 1'b1) begin
      $display("FAIL arb_overrun: got %b, expected 1", overrun);
      nerr++;
    end
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    o1 = int'($signed(out_sample));
    tick();
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    o2 = out_valid ? int'($signed(out_sample)) : -99999;
    nvec++;
    if (o1 !== eo || o2 !== eo2 || overrun !== 1'b1) begin
      $display("FAIL arb_two_frames: got %0d,%0d ovr %b, expected %0d,%0d ovr 1",
               o1, o2, overrun, eo, eo2);
      nerr++;
    end
    tick();
    tick();
    nvec++;
    if (busy !== 1'b0) begin
      $display("FAIL arb_dropped_idle: got busy %b, expected 0", busy);
      nerr++;
    end
  endtask

  task automatic test_reset_mid;
    int o, lat;
    apply_reset();
    nvec++;
    if (overrun !== 1'b0) begin
      $display("FAIL rst_clears_overrun: got %b, expected 0", overrun);
      nerr++;
    end
    record = 1'b1; loop = 1'b0; num_taps = 3'd4; delay_len = 8'd7;
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    nvec++;
    if ({mem_csb, busy} !== 2'b10) begin
      $display("FAIL rst_mid_frame: got csb/busy %b, expected 10", {mem_csb, busy});
      nerr++;
    end
    rst = 1'b0;
    tick();
    tick();
    nvec++;
    if (wq_addr.size() !== 0) begin
      $display("FAIL rst_no_write: got %0d writes, expected 0", wq_addr.size());
      nerr++;
    end
    num_taps = 3'd0; in_sample = 16'd123;
    do_frame(o, lat);
    nvec++;
    if (wq_addr.size() !== 1 || wq_addr[0] !== 0) begin
      $display("FAIL rst_wr_ptr: got %0d, expected 0", (wq_addr.size() > 0) ? wq_addr[0] : -1);
      nerr++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sample_stb = 1'b0; in_sample = '0; record = 1'b0; loop = 1'b0;
    delay_reverb = 1'b0; gain = '0; num_taps = '0; delay_len = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mem_init = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 0;
    tick();
    tick();
    mem_init = 1'b0;
    test_reset();
    test_delay();
    test_wrap();
    test_loop();
    test_random();
    test_reverb_sat();
    test_arbitration();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
